// File: rtl/mau_pkg.sv
// Shared op encoding, FSM states and op-decode helpers for the load/store sequencer.
package mau_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_LBU = 3'b011,
        OP_LHU = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_FMT,
        S_WR,
        S_ERR
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    function automatic logic is_store(input op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic size_e size(input op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input op_e op, input logic [1:0] lo);
        case (size(op))
            SZ_WORD: return lo != 2'b00;
            SZ_HALF: return lo[0];
            default: return 1'b0;
        endcase
    endfunction

    // Low address bits with the bits that a given access size ignores forced to zero.
    function automatic logic [1:0] align_lo(input op_e op, input logic [1:0] lo);
        case (size(op))
            SZ_WORD: return 2'b00;
            SZ_HALF: return {lo[1], 1'b0};
            default: return lo;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_fmt.sv
// Combinational lane logic: extracts/extends load data and merges a sub-word store into a memory word.
module mau_lane_fmt
    import mau_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  lane,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = mem_word[{lane, 3'b000} +: 8];
        half_v = mem_word[{lane[1], 4'b0000} +: 16];

        case (op)
            OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
            OP_LH:   load_data = {{16{half_v[15]}}, half_v};
            OP_LW:   load_data = mem_word;
            OP_LBU:  load_data = {24'b0, byte_v};
            OP_LHU:  load_data = {16'b0, half_v};
            default: load_data = 32'b0;
        endcase

        merged = mem_word;
        case (size(op))
            SZ_BYTE: merged[{lane, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer to a sync word memory: loads 3 cycles, SW 2, SB/SH read-modify-write 4; one request in flight,
// req_ready only in IDLE. MAU_ALIGN_CHK_EN routes misaligned requests to an error response instead of force-aligning.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-3:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_memwrite,
    output logic              dm_memread,
    input  logic [31:0]       dm_dout
);

    state_e            state, state_nxt;
    op_e               op_q;
    op_e               req_op_e;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic [31:0]       load_data;
    logic [31:0]       merged;
    logic              accept;

    assign req_op_e  = op_e'(req_op);
    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;

    mau_lane_fmt u_lane_fmt (
        .op        (op_q),
        .lane      (addr_q[1:0]),
        .mem_word  (dm_dout),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
`ifdef MAU_ALIGN_CHK_EN
                    if (misaligned(req_op_e, req_addr[1:0]))
                        state_nxt = S_ERR;
                    else
`endif
                    if (req_op_e == OP_SW)
                        state_nxt = S_WR;
                    else
                        state_nxt = S_RD;
                end
            end
            S_RD:  state_nxt = S_FMT;
            S_FMT: state_nxt = is_store(op_q) ? S_WR : S_IDLE;
            S_WR:  state_nxt = S_IDLE;
`ifdef MAU_ALIGN_CHK_EN
            S_ERR: state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Memory pins decode purely from state so a reset drops them in the same cycle.
    always_comb begin
        dm_addr     = '0;
        dm_din      = '0;
        dm_memwrite = 1'b0;
        dm_memread  = 1'b0;
        case (state)
            S_RD: begin
                dm_memread = 1'b1;
                dm_addr    = addr_q[ADDR_W-1:2];
            end
            S_WR: begin
                dm_memwrite = 1'b1;
                dm_addr     = addr_q[ADDR_W-1:2];
                dm_din      = (op_q == OP_SW) ? wdata_q : merge_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= OP_LB;
            addr_q     <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            resp_valid <= 1'b0;
            if (accept) begin
                op_q    <= req_op_e;
                addr_q  <= {req_addr[ADDR_W-1:2], align_lo(req_op_e, req_addr[1:0])};
                wdata_q <= req_wdata;
            end
            case (state)
                S_FMT: begin
                    if (is_store(op_q)) begin
                        merge_q <= merged;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                        resp_err   <= 1'b0;
                    end
                end
                S_WR: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
`ifdef MAU_ALIGN_CHK_EN
                S_ERR: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    resp_err   <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural sync-read word memory.
module tb_mem_access_unit;
    import mau_pkg::*;

    localparam int ADDR_W = 12;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-3:0] dm_addr;
    logic [31:0]       dm_din;
    logic              dm_memwrite;
    logic              dm_memread;
    logic [31:0]       dm_dout;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .dm_addr     (dm_addr),
        .dm_din      (dm_din),
        .dm_memwrite (dm_memwrite),
        .dm_memread  (dm_memread),
        .dm_dout     (dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (dm_memwrite) mem[dm_addr] <= dm_din;
        if (dm_memread)  dm_dout <= mem[dm_addr];
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wr_cnt = 0;
    int   rd_cnt = 0;
    int   both_cnt = 0;
    logic [ADDR_W-3:0] last_wr_addr = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   a;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                acc_q.delete();
            end else begin
                if (dm_memwrite) begin
                    wr_cnt++;
                    last_wr_addr = dm_addr;
                end
                if (dm_memread) rd_cnt++;
                if (dm_memwrite && dm_memread) both_cnt++;
                if (resp_valid) begin
                    if (sb.size() == 0 || acc_q.size() == 0) begin
                        chk("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        a = acc_q.pop_front();
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                        chk("resp_latency", 32'(cyc - a + 1), 32'(e.lat));
                    end
                end
                if (req_valid && req_ready) acc_q.push_back(cyc + 1);
            end
        end
    endtask

    task automatic send(input op_e op, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                        input logic exp_resp, input logic [31:0] erd, input logic eerr, input int elat,
                        output int waits, output logic rv_acc);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        if (exp_resp) begin
            e.rdata = erd;
            e.err   = eerr;
            e.lat   = elat;
            sb.push_back(e);
        end
        waits = 0;
        while (!req_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
        rv_acc = resp_valid;
        @(posedge clk);
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic op1(input op_e op, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr, input int elat);
        int   w;
        logic r;
        send(op, addr, wd, 1'b1, erd, eerr, elat, w, r);
        drain();
    endtask

    initial begin
        int   w0, w1, r0, n;
        logic rv0, rv1;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
        fork
            monitor();
            forever begin
                @(posedge clk);
                cyc++;
            end
        join_none

        repeat (2) @(negedge clk);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_dm_pins", {30'b0, dm_memwrite, dm_memread}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

        // Reset while an SB is in its write cycle must abort without writing or responding.
        op1(OP_SW, 12'h030, 32'h55667788, 32'h0, 1'b0, 2);
        send(OP_SB, 12'h031, 32'h000000AB, 1'b0, 32'h0, 1'b0, 0, w0, rv0);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!dm_memwrite && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_wr", {31'b0, dm_memwrite}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_memwrite_drop", {31'b0, dm_memwrite}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("abort_mem_kept", mem[12], 32'h55667788);

        w0 = wr_cnt;
        op1(OP_SW, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        chk("sw_write_pulses", 32'(wr_cnt - w0), 32'd1);
        chk("sw_word_addr", {22'b0, last_wr_addr}, 32'd4);
        op1(OP_LW, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3);

        op1(OP_SW,  12'h020, 32'h8899AABB, 32'h0,        1'b0, 2);
        op1(OP_LB,  12'h021, 32'h0,        32'hFFFFFFAA, 1'b0, 3);
        op1(OP_LBU, 12'h021, 32'h0,        32'h000000AA, 1'b0, 3);
        op1(OP_LH,  12'h022, 32'h0,        32'hFFFF8899, 1'b0, 3);
        op1(OP_LHU, 12'h020, 32'h0,        32'h0000AABB, 1'b0, 3);
        op1(OP_LB,  12'h020, 32'h0,        32'hFFFFFFBB, 1'b0, 3);
        op1(OP_LBU, 12'h023, 32'h0,        32'h00000088, 1'b0, 3);

        w0 = wr_cnt;
        op1(OP_SB, 12'h023, 32'h00000011, 32'h0, 1'b0, 4);
        chk("sb_write_pulses", 32'(wr_cnt - w0), 32'd1);
        chk("sb_merged_word", mem[8], 32'h1199AABB);
        w0 = wr_cnt;
        op1(OP_SH, 12'h020, 32'h00001234, 32'h0, 1'b0, 4);
        chk("sh_write_pulses", 32'(wr_cnt - w0), 32'd1);
        chk("sh_merged_word", mem[8], 32'h11991234);

        r0 = rd_cnt;
        w0 = wr_cnt;
`ifdef MAU_ALIGN_CHK_EN
        op1(OP_LW, 12'h022, 32'h0, 32'h0, 1'b1, 2);
        chk("misalign_reads", 32'(rd_cnt - r0), 32'd0);
`else
        op1(OP_LW, 12'h022, 32'h0, 32'h11991234, 1'b0, 3);
        chk("misalign_reads", 32'(rd_cnt - r0), 32'd1);
`endif
        chk("misalign_writes", 32'(wr_cnt - w0), 32'd0);

        // Back-to-back: the SW must wait exactly through RD and FMT of the LW.
        send(OP_LW, 12'h010, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 3, w0, rv0);
        send(OP_SW, 12'h014, 32'hCAFEF00D, 1'b1, 32'h0,        1'b0, 2, w1, rv1);
        chk("b2b_not_ready_cycles", 32'(w1), 32'd2);
        chk("b2b_accept_with_resp", {31'b0, rv1}, 32'd1);
        drain();
        chk("b2b_sw_word", mem[5], 32'hCAFEF00D);

        chk("rd_wr_overlap", 32'(both_cnt), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
